vga_line_writer: RTL and testbench
==================================

VGA_LINE_WRITER -- requirements
Module: vga_line_writer

Interface
REQ-001 Parameter H_RES, default 640, visible pixels per line.
REQ-002 Parameter V_RES, default 480, visible lines per frame.
REQ-003 iVGA_CLK  in  1  clock; all logic on its rising edge.
REQ-004 iRST_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  command strobe, one cycle.
REQ-006 mode  in  1  command type: 0 = line, 1 = clear screen.
REQ-007 x0, x1  in  10 each  line endpoints, unsigned.
REQ-008 y0, y1  in  9 each  line endpoints, unsigned.
REQ-009 color  in  8  palette index to write.
REQ-010 busy  out  1  high while a command is in progress.
REQ-011 done  out  1  one-cycle pulse when a command completes.
REQ-012 svga_we  out  1  frame-buffer write enable.
REQ-013 address_write  out  19  frame-buffer address, y*H_RES + x.
REQ-014 data_write  out  8  frame-buffer write data.

Function
REQ-015 The block SHALL have states IDLE, SETUP, DRAW, CLEAR and DONE.
REQ-016 In IDLE, start=1 SHALL latch mode, endpoints and color, and move to SETUP; busy SHALL rise the next cycle.
REQ-017 start SHALL be ignored while busy=1 or done=1; latched operands SHALL NOT change.
REQ-018 In SETUP (one cycle), the block SHALL compute the following as 12-bit signed values:
- dx = |x1-x0|
- dy = -|y1-y0|
- sx/sy = +1 or -1 by direction
- err = dx+dy
REQ-019 From SETUP, the block SHALL go to DRAW if mode=0, or to CLEAR if mode=1.
REQ-020 In DRAW, the block SHALL emit exactly one pixel (x,y) per cycle, starting at (x0,y0).
REQ-021 The DRAW step SHALL be standard Bresenham:
- e2 = 2*err
- if e2 >= dy: err += dy, x += sx
- if e2 <= dx: err += dx, y += sy
- both updates SHALL use the same old err.
REQ-022 DRAW SHALL end on the cycle that emits (x1,y1); the pixel count SHALL equal max(dx,-dy)+1.
REQ-023 A pixel with x >= H_RES or y >= V_RES SHALL be clipped:
- svga_we SHALL be 0 for that pixel
- the cycle SHALL still be consumed
- stepping SHALL continue.
REQ-024 For an unclipped pixel, svga_we SHALL be 1 with address_write = y*H_RES + x and data_write = color, all registered.
REQ-025 The first write SHALL appear 2 cycles after the start cycle.
REQ-026 In CLEAR, the block SHALL write color to addresses 0 .. H_RES*V_RES-1 in ascending order, one per cycle, with no gaps.
REQ-027 After the last write of either mode, the block SHALL enter DONE for one cycle:
- done=1, busy=0, svga_we=0
- then return to IDLE.
REQ-028 Outside DRAW/CLEAR write cycles, svga_we SHALL be 0; address_write and data_write SHALL hold their last values.
REQ-029 The multiply y*H_RES SHALL be exact for y < 512 with a 19-bit result.

Reset
REQ-030 iRST_n=0 SHALL force the following asynchronously:
- state IDLE
- busy=0, done=0, svga_we=0
- address_write=0, data_write=0
- all internal coordinates and error terms cleared.
REQ-031 A reset asserted mid-command SHALL abort the command without a done pulse; writes SHALL stop on reset assertion.
REQ-032 The first start after reset release SHALL be accepted normally.

Verification
REQ-033 Reset: drive iRST_n=0 mid-DRAW -> svga_we=0, busy=0 and address_write=0 immediately; no done pulse.
REQ-034 Horizontal line: line (0,0)->(3,0), color 0x1F -> four writes:
- addresses 0,1,2,3, data 0x1F, on cycles start+2..start+5
- done at start+6.
REQ-035 Single point: (5,2)->(5,2), color 0xA5 -> exactly one write at address 1285, then done the next cycle.
REQ-036 Reverse diagonal: (639,479)->(636,476) -> writes at 307199, 306558, 305917, 305276 in that order.
REQ-037 Clipping: (638,10)->(641,10) -> writes at 7038 and 7039 only; four DRAW cycles; done at start+6.
REQ-038 Clear with busy-start: clear with color 0x00 -> 307200 consecutive writes, addresses 0..307199; done one cycle after address 307199; a second start issued mid-clear is ignored.

Source files
------------

// File: rtl/vga_line_writer.sv
// Frame-buffer writer: draws a Bresenham line or clears the whole screen,
// issuing one registered frame-buffer write per cycle.
module vga_line_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        start,
  input  logic        mode,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [7:0]  color,
  output logic        busy,
  output logic        done,
  output logic        svga_we,
  output logic [18:0] address_write,
  output logic [7:0]  data_write,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_DRAW  = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);

  state_t             state;
  logic               mode_q;
  logic [7:0]         color_q;
  logic signed [11:0] x0_q, x1_q, y0_q, y1_q;
  logic signed [11:0] x, y, dx, dy, sx, sy, err;

  logic signed [11:0] ddx, ddy, e2, nx, ny, nerr, px, py;
  logic               vis;
  logic [18:0]        paddr;

  assign state_dbg = state;

  // Handshake: start is a single-cycle strobe sampled only in IDLE; busy
  // covers SETUP/DRAW/CLEAR, done pulses for one cycle, and svga_we qualifies
  // address_write/data_write on each cycle it is high.
  always_comb begin
    ddx = x1_q - x0_q;
    if (ddx < 0) ddx = -ddx;
    ddy = y1_q - y0_q;
    if (ddy > 0) ddy = -ddy;
    e2   = err <<< 1;
    nx   = x;
    ny   = y;
    nerr = err;
    // Both corrections are decided from the same pre-step error term.
    if (e2 >= dy) begin
      nerr = nerr + dy;
      nx   = x + sx;
    end
    if (e2 <= dx) begin
      nerr = nerr + dx;
      ny   = y + sy;
    end
    px    = (state == S_SETUP) ? x0_q : nx;
    py    = (state == S_SETUP) ? y0_q : ny;
    vis   = (int'(px) < H_RES) && (int'(py) < V_RES);
    paddr = 19'(py) * 19'(H_RES) + 19'(px);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      svga_we       <= 1'b0;
      address_write <= '0;
      data_write    <= '0;
      mode_q        <= 1'b0;
      color_q       <= '0;
      x0_q          <= '0;
      x1_q          <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      x             <= '0;
      y             <= '0;
      dx            <= '0;
      dy            <= '0;
      sx            <= '0;
      sy            <= '0;
      err           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          svga_we <= 1'b0;
          if (start) begin
            mode_q  <= mode;
            color_q <= color;
            x0_q    <= 12'(x0);
            x1_q    <= 12'(x1);
            y0_q    <= 12'(y0);
            y1_q    <= 12'(y1);
            busy    <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          dx  <= ddx;
          dy  <= ddy;
          sx  <= (x0_q < x1_q) ? 12'sd1 : -12'sd1;
          sy  <= (y0_q < y1_q) ? 12'sd1 : -12'sd1;
          err <= ddx + ddy;
          x   <= x0_q;
          y   <= y0_q;
          // The first pixel is registered here so it appears on entry to DRAW/CLEAR.
          if (mode_q) begin
            state         <= S_CLEAR;
            svga_we       <= 1'b1;
            address_write <= '0;
            data_write    <= color_q;
          end else begin
            state   <= S_DRAW;
            svga_we <= vis;
            if (vis) begin
              address_write <= paddr;
              data_write    <= color_q;
            end
          end
        end
        S_DRAW: begin
          if (x == x1_q && y == y1_q) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            svga_we <= 1'b0;
          end else begin
            x       <= nx;
            y       <= ny;
            err     <= nerr;
            svga_we <= vis;
            if (vis) begin
              address_write <= paddr;
              data_write    <= color_q;
            end
          end
        end
        S_CLEAR: begin
          if (address_write == LAST_ADDR) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            svga_we <= 1'b0;
          end else begin
            address_write <= address_write + 19'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_line_writer.sv
// Bench for vga_line_writer: line vectors on a full-size instance, screen
// clear on a small instance, plus reset-abort and ignored-start sequences.
module tb_vga_line_writer;

  logic        clk;
  logic        rst_n;
  logic        start, mode, use_s;
  logic [9:0]  x0, x1;
  logic [8:0]  y0, y1;
  logic [7:0]  color;

  logic        busy_m, done_m, we_m, busy_s, done_s, we_s;
  logic [18:0] addr_m, addr_s;
  logic [7:0]  data_m, data_s;
  logic [2:0]  st_m, st_s;
  logic        m_busy, m_done, m_we;
  logic [18:0] m_addr;
  logic [7:0]  m_data;

  logic [26:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  vga_line_writer dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .start(start && !use_s), .mode(mode),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .busy(busy_m), .done(done_m), .svga_we(we_m),
    .address_write(addr_m), .data_write(data_m), .state_dbg(st_m)
  );

  vga_line_writer #(.H_RES(20), .V_RES(12)) dut_s (
    .iVGA_CLK(clk), .iRST_n(rst_n), .start(start && use_s), .mode(mode),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .busy(busy_s), .done(done_s), .svga_we(we_s),
    .address_write(addr_s), .data_write(data_s), .state_dbg(st_s)
  );

  assign m_busy = use_s ? busy_s : busy_m;
  assign m_done = use_s ? done_s : done_m;
  assign m_we   = use_s ? we_s   : we_m;
  assign m_addr = use_s ? addr_s : addr_m;
  assign m_data = use_s ? data_s : data_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ax0, ay0, ax1, ay1;
    logic [7:0] c;
    int poke;
    int nw, lat, first_a, last_a;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference Bresenham on a 640x480 screen; pushes expected {addr, data}.
  task automatic push_line(input int ax0, ay0, ax1, ay1, input logic [7:0] c);
    int dx, dy, sx, sy, err, e2, px, py, n;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    px = ax0;
    py = ay0;
    for (n = 0; n < 2000; n++) begin
      if (px < 640 && py < 480) exp_q.push_back({19'(py * 640 + px), c});
      if (px == ax1 && py == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
    end
  endtask

  task automatic run_cmd(input logic m, input int ax0, ay0, ax1, ay1,
                         input logic [7:0] c, input int poke,
                         input int exp_nw, exp_lat, exp_first, exp_last);
    int lat, nw, first_lat;
    logic [18:0] first_a, last_a;
    logic [26:0] e;
    if (!m) push_line(ax0, ay0, ax1, ay1, c);
    else for (int a = 0; a < exp_nw; a++) exp_q.push_back({19'(a), c});
    nw = 0; first_lat = 0; first_a = '0; last_a = '0;
    @(posedge clk); #1;
    mode = m; x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1);
    color = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 1000) begin
      @(negedge clk);
      if (m_done) break;
      if (m_we) begin
        nw++;
        if (nw == 1) begin first_lat = lat; first_a = m_addr; end
        last_a = m_addr;
        if (exp_q.size() == 0) chk("extra_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", m_addr, e[26:8]);
          chk("wr_data", m_data, e[7:0]);
        end
      end
      @(posedge clk);
      lat++;
      if (lat == poke) begin
        #1; start = 1'b1; color = 8'hEE; x0 = 10'd100;
      end else if (lat == poke + 1) begin
        #1; start = 1'b0;
      end
    end
    chk("done_lat", lat, exp_lat);
    chk("write_count", nw, exp_nw);
    if (exp_nw > 0) begin
      chk("first_wr_lat", first_lat, 2);
      chk("first_addr", first_a, exp_first);
      chk("last_addr", last_a, exp_last);
    end
    chk("busy_at_done", m_busy, 0);
    chk("we_at_done", m_we, 0);
    chk("leftover_exp", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", m_busy, 0);
    chk("idle_done", m_done, 0);
    chk("idle_we", m_we, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 3, 0, 8'h1F, -5, 4, 6, 0, 3};
    vecs[1] = '{5, 2, 5, 2, 8'hA5, 3, 1, 3, 1285, 1285};
    vecs[2] = '{639, 479, 636, 476, 8'h3C, -5, 4, 6, 307199, 305276};
    vecs[3] = '{638, 10, 641, 10, 8'h77, -5, 2, 6, 7038, 7039};
    vecs[4] = '{3, 5, 3, 9, 8'h42, 4, 5, 7, 3203, 5763};
    vecs[5] = '{0, 0, 2, 5, 8'h99, -5, 6, 8, 0, 3202};
    vecs[6] = '{10, 478, 10, 481, 8'h10, -5, 2, 6, 305930, 306570};
    vecs[7] = '{700, 0, 702, 0, 8'h55, -5, 0, 5, 0, 0};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; use_s = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_we", we_m, 0);
    chk("rst_addr", addr_m, 0);
    chk("rst_data", data_m, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_cmd(1'b0, vecs[i].ax0, vecs[i].ay0, vecs[i].ax1, vecs[i].ay1, vecs[i].c,
              vecs[i].poke, vecs[i].nw, vecs[i].lat, vecs[i].first_a, vecs[i].last_a);

    // Reset asserted in the middle of a long line.
    @(posedge clk); #1;
    mode = 1'b0; x0 = 10'd0; y0 = 9'd0; x1 = 10'd20; y1 = 9'd0; color = 8'h33;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_we", we_m, 1);
    chk("pre_rst_busy", busy_m, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we", we_m, 0);
    chk("abort_busy", busy_m, 0);
    chk("abort_addr", addr_m, 0);
    chk("abort_data", data_m, 0);
    chk("abort_state", st_m, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", done_m, 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done_m, 0);
    chk("post_rst_we", we_m, 0);

    run_cmd(1'b0, 1, 1, 2, 2, 8'h0F, -5, 2, 4, 641, 1282);

    // Clear on the 20x12 instance with a stray start during the clear.
    use_s = 1'b1;
    run_cmd(1'b1, 0, 0, 0, 0, 8'h00, 50, 240, 242, 0, 239);
    use_s = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
